// File: rtl/logic_seq_pkg.sv
// Shared definitions for the logic-op sequencer: opcodes, FSM states,
// program-entry layout and the default program depth.
package logic_seq_pkg;

  localparam int DEPTH_DEFAULT = 8;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } entry_t;

endpackage

// File: rtl/logic_op_4bit.sv
// Combinational 4-bit bitwise logic unit; the reserved opcode yields zero
// with the error flag raised.
module logic_op_4bit
  import logic_seq_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_y,
  output logic       o_err
);

  always_comb begin
    o_y   = 4'h0;
    o_err = 1'b0;
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_NAND: o_y = ~(i_a & i_b);
      OP_NOR:  o_y = ~(i_a | i_b);
      OP_XOR:  o_y = i_a ^ i_b;
      OP_XNOR: o_y = ~(i_a ^ i_b);
      OP_NOT:  o_y = ~i_a;
      default: begin
        o_y   = 4'h0;
        o_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// Runs a stored program of bitwise ops and streams one result per entry
// through a valid/ready output register.
module logic_op_sequencer
  import logic_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [IW-1:0] prog_addr,
  input  logic [2:0]    prog_op,
  input  logic [3:0]    prog_a,
  input  logic [3:0]    prog_b,
  input  logic          start,
  input  logic [3:0]    len,
  output logic          busy,
  output logic          done,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [3:0]    res_data,
  output logic [IW-1:0] res_idx,
  output logic          res_err
);

  state_t        r_state;
  state_t        w_state_next;
  entry_t        r_mem [DEPTH];
  logic [IW-1:0] r_last_idx;
  logic          r_res_valid;
  logic [3:0]    r_res_data;
  logic [IW-1:0] r_res_idx;
  logic          r_res_err;

  logic [DEPTH-1:0] w_we;
  logic             w_wr_ok;
  entry_t           w_wr_entry;
  logic [IW-1:0]    w_rd_idx;
  entry_t           w_rd_entry;
  logic [IW-1:0]    w_last_idx;
  logic             w_load;
  logic [3:0]       w_y;
  logic             w_err;

  // A start in the same cycle wins over a program write.
  assign w_wr_ok    = (r_state == S_IDLE) && prog_we && !start;
  assign w_wr_entry = entry_t'({prog_op, prog_a, prog_b});

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign w_we[gi] = w_wr_ok && (prog_addr == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we[i]) r_mem[i] <= w_wr_entry;
      end
    end
  end

  // IDLE preloads entry 0; STREAM prefetches the entry after the one on display.
  assign w_rd_idx   = (r_state == S_STREAM) ? r_res_idx + 1'b1 : '0;
  assign w_rd_entry = r_mem[w_rd_idx];
  assign w_last_idx = (32'(len) >= DEPTH) ? IW'(DEPTH - 1) : IW'(len - 4'd1);

  logic_op_4bit u_alu (
    .i_op  (w_rd_entry.op),
    .i_a   (w_rd_entry.a),
    .i_b   (w_rd_entry.b),
    .o_y   (w_y),
    .o_err (w_err)
  );

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == 4'd0) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_STREAM;
            w_load       = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (res_ready) begin
          if (r_res_idx == r_last_idx) w_state_next = S_DONE;
          else                         w_load       = 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last_idx  <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= 4'h0;
      r_res_idx   <= '0;
      r_res_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_res_valid <= (w_state_next == S_STREAM);
      if (r_state == S_IDLE && start) r_last_idx <= w_last_idx;
      if (w_load) begin
        r_res_data <= w_y;
        r_res_err  <= w_err;
        r_res_idx  <= w_rd_idx;
      end
    end
  end

  assign busy      = (r_state == S_STREAM);
  assign done      = (r_state == S_DONE);
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_idx   = r_res_idx;
  assign res_err   = r_res_err;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Self-checking bench: table-driven programs, hand-written corner sequences
// and randomized runs compared against a behavioural model.
module tb_logic_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [2:0] prog_op;
  logic [3:0] prog_a;
  logic [3:0] prog_b;
  logic       start;
  logic [3:0] len;
  logic       busy;
  logic       done;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [2:0] res_idx;
  logic       res_err;

  always #5 clk = ~clk;

  logic_op_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_op   (prog_op),
    .prog_a    (prog_a),
    .prog_b    (prog_b),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_err   (res_err)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int   idx;
    int   y;
    int   err;
  } res_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    int         exp_y;
    int         exp_err;
  } vec_t;

  res_t       expq[$];
  logic [2:0] m_op [8];
  logic [3:0] m_a  [8];
  logic [3:0] m_b  [8];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: the opcode table applied to 4-bit operands.
  function automatic res_t ref_res(int idx, logic [2:0] op, logic [3:0] a, logic [3:0] b);
    res_t r;
    logic [3:0] y;
    r.idx = idx;
    r.err = 0;
    case (op)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: y = ~(a & b);
      3'd3: y = ~(a | b);
      3'd4: y = a ^ b;
      3'd5: y = ~(a ^ b);
      3'd6: y = ~a;
      default: begin y = 4'h0; r.err = 1; end
    endcase
    r.y = int'(y);
    return r;
  endfunction

  task automatic prog_write(input int addr, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    prog_we   = 1'b1;
    prog_addr = 3'(addr);
    prog_op   = op;
    prog_a    = a;
    prog_b    = b;
    cyc();
    prog_we   = 1'b0;
    m_op[addr] = op;
    m_a[addr]  = a;
    m_b[addr]  = b;
    $display("write  entry=%0d op=%0d a=%0h b=%0h", addr, op, a, b);
  endtask

  task automatic fill_expected(input int l);
    int n;
    n = (l > 8) ? 8 : l;
    for (int i = 0; i < n; i++) expq.push_back(ref_res(i, m_op[i], m_a[i], m_b[i]));
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for 4 cycles first
  task automatic run(input logic [3:0] l, input int mode, input bit sbusy, input bit collide, input string tag);
    int   stall_left = 4;
    bit   prev_stall = 0;
    bit   done_seen  = 0;
    bit   r;
    int   cycles = 0;
    int   n_expect;
    int   n_got = 0;
    logic [8:0] prev_out = '0;
    res_t e;
    n_expect = expq.size();
    start = 1'b1;
    len   = l;
    if (collide) begin
      prog_we   = 1'b1;
      prog_addr = 3'd0;
      prog_op   = ~m_op[0];
      prog_a    = ~m_a[0];
      prog_b    = ~m_b[0];
    end
    cyc();
    start   = 1'b0;
    prog_we = 1'b0;
    len     = 4'($urandom);
    chk({tag, " first_valid"}, int'(res_valid), int'(n_expect > 0));
    if (n_expect > 0) chk({tag, " first_idx"}, int'(res_idx), 0);
    else              chk({tag, " len0_done"}, int'(done), 1);
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        done_seen = 1;
        chk({tag, " busy_in_done"}, int'(busy), 0);
        chk({tag, " valid_in_done"}, int'(res_valid), 0);
        break;
      end
      chk({tag, " busy"}, int'(busy), 1);
      chk({tag, " valid"}, int'(res_valid), 1);
      if (prev_stall) chk({tag, " hold"}, int'({res_data, res_idx, res_err}), int'(prev_out));
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: begin
          if (stall_left > 0) begin r = 1'b0; stall_left--; end
          else r = 1'b1;
        end
      endcase
      res_ready = r;
      if (res_valid && r) begin
        if (expq.size() == 0) begin
          chk({tag, " extra_result"}, 1, 0);
        end else begin
          e = expq.pop_front();
          chk({tag, " idx"}, int'(res_idx), e.idx);
          chk({tag, " data"}, int'(res_data), e.y);
          chk({tag, " err"}, int'(res_err), e.err);
          $display("%s result idx=%0d data=%0h err=%0d", tag, res_idx, res_data, res_err);
          n_got++;
        end
      end
      prev_stall = res_valid && !r;
      prev_out   = {res_data, res_idx, res_err};
      if (sbusy) start = 1'($urandom_range(0, 1));
      cyc();
      cycles++;
    end
    start     = 1'b0;
    res_ready = 1'b0;
    chk({tag, " done_seen"}, int'(done_seen), 1);
    chk({tag, " results_lost"}, expq.size(), 0);
    expq.delete();
    if (mode == 0) chk({tag, " done_latency"}, cycles, n_expect);
    cyc();
    chk({tag, " done_one_cycle"}, int'(done), 0);
    chk({tag, " busy_after"}, int'(busy), 0);
    cyc();
    chk({tag, " no_second_run"}, int'(res_valid), 0);
    $display("run    %s len=%0d mode=%0d results=%0d cycles=%0d", tag, l, mode, n_got, cycles);
  endtask

  vec_t tbl [12];

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_op = '0; prog_a = '0; prog_b = '0;
    start = 1'b0; len = '0; res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin m_op[i] = '0; m_a[i] = '0; m_b[i] = '0; end
    cyc();
    cyc();
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset valid", int'(res_valid), 0);
    chk("reset data", int'(res_data), 0);
    chk("reset idx", int'(res_idx), 0);
    chk("reset err", int'(res_err), 0);
    reset = 1'b0;
    cyc();

    tbl[0]  = '{3'd0, 4'hC, 4'hA, 'h8, 0};
    tbl[1]  = '{3'd5, 4'hC, 4'hA, 'h9, 0};
    tbl[2]  = '{3'd1, 4'h3, 4'h8, 'hB, 0};
    tbl[3]  = '{3'd2, 4'hF, 4'h5, 'hA, 0};
    tbl[4]  = '{3'd3, 4'h1, 4'h2, 'hC, 0};
    tbl[5]  = '{3'd4, 4'hF, 4'hA, 'h5, 0};
    tbl[6]  = '{3'd6, 4'h0, 4'hF, 'hF, 0};
    tbl[7]  = '{3'd1, 4'h0, 4'h0, 'h0, 0};
    tbl[8]  = '{3'd6, 4'h5, 4'h3, 'hA, 0};
    tbl[9]  = '{3'd7, 4'hF, 4'hF, 'h0, 1};
    tbl[10] = '{3'd4, 4'h6, 4'h6, 'h0, 0};
    tbl[11] = '{3'd2, 4'h0, 4'h0, 'hF, 0};
    for (int bt = 0; bt < 2; bt++) begin
      int base = bt * 8;
      int n    = (bt == 0) ? 8 : 4;
      for (int i = 0; i < n; i++) begin
        prog_write(i, tbl[base + i].op, tbl[base + i].a, tbl[base + i].b);
        expq.push_back('{i, tbl[base + i].exp_y, tbl[base + i].exp_err});
      end
      run(4'(n), 0, 0, 0, (bt == 0) ? "table1" : "table2");
    end

    prog_write(0, 3'd0, 4'hC, 4'hA);
    prog_write(1, 3'd5, 4'hC, 4'hA);
    fill_expected(2);
    run(4'd2, 0, 0, 0, "and_xnor");

    fill_expected(3);
    run(4'd3, 2, 0, 0, "stall");

    fill_expected(0);
    run(4'd0, 0, 0, 0, "len0");

    fill_expected(12);
    run(4'd12, 1, 0, 0, "len12");

    fill_expected(1);
    run(4'd1, 0, 0, 1, "collide");
    fill_expected(1);
    run(4'd1, 0, 0, 0, "after_collide");

    fill_expected(8);
    run(4'd8, 1, 1, 0, "start_busy");

    // Reset in the middle of a stream, with start and a write competing.
    start = 1'b1; len = 4'd8;
    cyc();
    start = 1'b0; res_ready = 1'b1;
    begin
      bit hit = 0;
      for (int c = 0; c < 20; c++) begin
        if (res_valid && res_idx == 3'd2) begin hit = 1; break; end
        cyc();
      end
      chk("midreset reach_idx2", int'(hit), 1);
    end
    reset = 1'b1; start = 1'b1; prog_we = 1'b1; prog_addr = 3'd3;
    prog_op = 3'd6; prog_a = 4'h0; prog_b = 4'h0;
    cyc();
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    chk("midreset valid", int'(res_valid), 0);
    chk("midreset data", int'(res_data), 0);
    chk("midreset idx", int'(res_idx), 0);
    chk("midreset err", int'(res_err), 0);
    reset = 1'b0; start = 1'b0; prog_we = 1'b0; res_ready = 1'b0;
    cyc();
    chk("midreset start_ignored", int'(res_valid), 0);
    $display("reset  mid-stream at idx 2");
    for (int i = 0; i < 8; i++) begin m_op[i] = '0; m_a[i] = '0; m_b[i] = '0; end
    fill_expected(8);
    run(4'd8, 0, 0, 0, "cleared");

    for (int it = 0; it < 20; it++) begin
      int nw = $urandom_range(0, 3);
      logic [3:0] l;
      for (int w = 0; w < nw; w++)
        prog_write($urandom_range(0, 7), 3'($urandom), 4'($urandom), 4'($urandom));
      l = 4'($urandom);
      fill_expected(int'(l));
      run(l, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
